// File: rtl/wb_select_stage.sv
// Registered write-back select stage. Picks one register-file write source
// per instruction (load-immediate > memory load > move > ALU result),
// stalls upstream while a load waits on memory, and aborts the load with a
// one-cycle mem_err pulse if memory stays silent for TIMEOUT cycles.
// Writes to register 0 update wb_addr/wb_data but never assert wb_en.
module wb_select_stage #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              is_li,
  input  logic              is_mem_access,
  input  logic              is_move,
  input  logic [ADDR_W-1:0] dest_reg,
  input  logic [DATA_W-1:0] immediate,
  input  logic [DATA_W-1:0] reg_read_data,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic              stall,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [ADDR_W-1:0] pend_addr, pend_next;
  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [DATA_W-1:0] sel_data;
  logic              err_next;
  logic              is_load;

  // Fixed-priority source select; depends only on the instruction flags.
  always_comb begin
    if (is_li)
      sel_data = immediate;
    else if (is_mem_access)
      sel_data = mem_data;
    else if (is_move)
      sel_data = reg_read_data;
    else
      sel_data = result;
  end

  assign is_load = is_mem_access && !is_li;

  // Next-state, commit and stall decode.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pend_next   = pend_addr;
    commit      = 1'b0;
    commit_addr = dest_reg;
    commit_data = sel_data;
    err_next    = 1'b0;
    stall       = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_load && !mem_ready) begin
            stall      = 1'b1;
            state_next = WAIT_MEM;
            cnt_next   = CNT_W'(1);
            pend_next  = dest_reg;
          end else begin
            commit = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        stall       = 1'b1;
        commit_addr = pend_addr;
        commit_data = mem_data;
        // mem_ready takes precedence over an expiring timeout.
        if (mem_ready) begin
          commit     = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if ((TIMEOUT != 0) && (cnt == TIMEOUT_CNT)) begin
          err_next   = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt != '1) begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and write-back output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_addr <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      mem_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pend_addr <= pend_next;
      wb_en     <= commit && (commit_addr != '0);
      mem_err   <= err_next;
      if (commit) begin
        wb_addr <= commit_addr;
        wb_data <= commit_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage with TIMEOUT=4.
module tb_wb_select_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, is_li, is_mem_access, is_move, mem_ready;
  logic [2:0] dest_reg;
  logic [7:0] immediate, reg_read_data, result, mem_data;
  logic       stall, wb_en, mem_err;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;

  int unsigned pass_cnt = 0;
  int unsigned total    = 0;

  always #5 clk = ~clk;

  wb_select_stage #(
    .DATA_W (8),
    .ADDR_W (3),
    .TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .is_li        (is_li),
    .is_mem_access(is_mem_access),
    .is_move      (is_move),
    .dest_reg     (dest_reg),
    .immediate    (immediate),
    .reg_read_data(reg_read_data),
    .result       (result),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .stall        (stall),
    .wb_en        (wb_en),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .mem_err      (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [2:0] a,
                          input logic [7:0] d, input logic err);
    check({tag, "_wb_en"}, 32'(wb_en), 32'(en));
    check({tag, "_wb_addr"}, 32'(wb_addr), 32'(a));
    check({tag, "_wb_data"}, 32'(wb_data), 32'(d));
    check({tag, "_mem_err"}, 32'(mem_err), 32'(err));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; is_li = 1'b1; is_mem_access = 1'b1;
    is_move = 1'b1; mem_ready = 1'b0; dest_reg = 3'd6; immediate = 8'hE7;
    reg_read_data = 8'h3B; result = 8'h91; mem_data = 8'h4D;
    #1;
    // Reset held for two edges
    step(); step();
    check_wb("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    check("reset_stall", 32'(stall), 32'(0));
    rst_n = 1'b1;

    // Priority: load-immediate wins over everything
    in_valid = 1'b1; is_li = 1'b1; is_mem_access = 1'b1; is_move = 1'b1;
    immediate = 8'h5A; dest_reg = 3'd3; mem_ready = 1'b0; mem_data = 8'h77;
    #1 check("li_stall", 32'(stall), 32'(0));
    step();
    check_wb("li", 1'b1, 3'd3, 8'h5A, 1'b0);

    // Move beats ALU result
    is_li = 1'b0; is_mem_access = 1'b0; is_move = 1'b1;
    reg_read_data = 8'h00; result = 8'hFF; dest_reg = 3'd6;
    step();
    check_wb("move", 1'b1, 3'd6, 8'h00, 1'b0);

    // ALU result, back-to-back commit
    is_move = 1'b0; result = 8'hA5; dest_reg = 3'd7;
    step();
    check_wb("alu", 1'b1, 3'd7, 8'hA5, 1'b0);

    // Register 0: data/addr update, no write strobe
    is_move = 1'b1; reg_read_data = 8'h11; dest_reg = 3'd0;
    step();
    check_wb("zero_reg", 1'b0, 3'd0, 8'h11, 1'b0);

    // No instruction: outputs hold
    in_valid = 1'b0; result = 8'h22; dest_reg = 3'd2;
    step();
    check_wb("idle_hold", 1'b0, 3'd0, 8'h11, 1'b0);

    // Load with memory ready in the issue cycle
    in_valid = 1'b1; is_move = 1'b0; is_mem_access = 1'b1; mem_ready = 1'b1;
    mem_data = 8'h3C; dest_reg = 3'd4;
    #1 check("fastload_stall", 32'(stall), 32'(0));
    step();
    check_wb("fastload", 1'b1, 3'd4, 8'h3C, 1'b0);

    // Stalled load: ready arrives on the fourth stall cycle
    mem_ready = 1'b0; dest_reg = 3'd5;
    #1 check("sload_stall0", 32'(stall), 32'(1));
    step();
    in_valid = 1'b0; dest_reg = 3'd2; is_li = 1'b1; immediate = 8'h99;
    #1 check("sload_stall1", 32'(stall), 32'(1));
    check_wb("sload_wait1", 1'b0, 3'd4, 8'h3C, 1'b0);
    step();
    check("sload_stall2", 32'(stall), 32'(1));
    step();
    check("sload_stall3", 32'(stall), 32'(1));
    mem_ready = 1'b1; mem_data = 8'hC3;
    step();
    check_wb("sload_commit", 1'b1, 3'd5, 8'hC3, 1'b0);
    check("sload_stall_after", 32'(stall), 32'(0));

    // Timeout: no ready at all
    is_li = 1'b0; in_valid = 1'b1; is_mem_access = 1'b1; mem_ready = 1'b0;
    dest_reg = 3'd1; mem_data = 8'h66;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("tmo_noerr%0d", i), 32'(mem_err), 32'(0));
      check($sformatf("tmo_stall%0d", i), 32'(stall), 32'(1));
    end
    step();
    check_wb("tmo_abort", 1'b0, 3'd5, 8'hC3, 1'b1);
    check("tmo_stall_after", 32'(stall), 32'(0));
    step();
    check("tmo_err_drop", 32'(mem_err), 32'(0));

    // Ready on the final timeout cycle wins
    in_valid = 1'b1; dest_reg = 3'd6;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    mem_ready = 1'b1; mem_data = 8'h9E;
    step();
    check_wb("tmo_ready", 1'b1, 3'd6, 8'h9E, 1'b0);
    check("tmo_ready_stall", 32'(stall), 32'(0));

    // Reset during WAIT_MEM aborts the load
    in_valid = 1'b1; mem_ready = 1'b0; dest_reg = 3'd3; mem_data = 8'h12;
    step();
    in_valid = 1'b0;
    #1 check("rst_wait_stall", 32'(stall), 32'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_wb("rst_wait", 1'b0, 3'd0, 8'h00, 1'b0);
    check("rst_wait_idle", 32'(stall), 32'(0));
    mem_ready = 1'b1;
    step();
    check_wb("rst_after", 1'b0, 3'd0, 8'h00, 1'b0);
    check("rst_after_idle", 32'(stall), 32'(0));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Registered, parametrised write-back stage for the MIPS processor. It replaces the combinational write-back data mux with a clocked stage. Each cycle it selects one source for the register-file write: load-immediate, memory load, register move, or ALU result. Memory loads may take several cycles: the stage stalls upstream until memory answers, and reports an error if memory stays silent too long. Writes to register 0 are suppressed.

## Interface
- DATA_W, 8, data path width
- ADDR_W, 3, register-file address width
- TIMEOUT, 15, WAIT_MEM cycles without mem_ready before abort; 0 = never time out
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction present this cycle
- is_li  in  1  load-immediate
- is_mem_access  in  1  memory load
- is_move  in  1  register move
- dest_reg  in  ADDR_W  destination register
- immediate  in  DATA_W  immediate value
- reg_read_data  in  DATA_W  source register value for moves
- result  in  DATA_W  ALU result
- mem_data  in  DATA_W  load data, valid when mem_ready=1
- mem_ready  in  1  memory data valid this cycle
- stall  out  1  combinational; upstream holds its instruction while 1
- wb_en  out  1  register-file write strobe, one-cycle pulse
- wb_addr  out  ADDR_W  write address
- wb_data  out  DATA_W  write data
- mem_err  out  1  one-cycle pulse when a load times out

## Operation
- Source priority is fixed: is_li > is_mem_access > is_move > result. Selection depends only on the flags, never on data values.
- States: IDLE and WAIT_MEM. Timeout counter width is $clog2(TIMEOUT+1), minimum 1.
- IDLE with in_valid=0: no commit.
- IDLE, in_valid=1, not a load (is_li=1, or is_mem_access=0):
  - Commit the selected source at the edge.
- IDLE, in_valid=1, load (is_mem_access=1, is_li=0):
  - mem_ready=1: commit mem_data at the edge, stay in IDLE.
  - mem_ready=0: capture dest_reg, move to WAIT_MEM, set counter to 1.
- WAIT_MEM:
  - in_valid and all source inputs except mem_data/mem_ready are ignored.
  - mem_ready=1: commit mem_data to the captured register, go to IDLE. mem_ready wins even on the final timeout cycle.
  - mem_ready=0 and counter==TIMEOUT (TIMEOUT≠0): pulse mem_err, no commit, go to IDLE. The instruction is dropped.
  - Otherwise: increment the counter, saturating.
- stall = (state==WAIT_MEM) | (state==IDLE & in_valid & is_mem_access & !is_li & !mem_ready).
- A commit sets wb_addr and wb_data. wb_en=1 only if the address ≠ 0; a commit to register 0 updates wb_addr and wb_data with wb_en=0.
- Without a commit, wb_en=0 and wb_addr/wb_data hold their last values.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, counter=0, wb_en=0, wb_addr=0, wb_data=0, mem_err=0.
- Reset during WAIT_MEM aborts the load: no commit, no mem_err.
- rst_n is not sampled between edges.
- Latency:
  - Non-load, or load with mem_ready in the issue cycle: inputs sampled at edge N, outputs valid after edge N.
  - Stalled load: commit at the edge where mem_ready=1 is sampled.
- stall rises in the issue cycle, with no registered delay. It falls in the cycle after the commit or timeout edge. The upstream instruction is accepted at the edge where stall=0.
- Back-to-back non-load instructions commit every cycle, so wb_en can stay high continuously.
- Timeout, with load issued at edge 0 and no ready: mem_err asserts after edge TIMEOUT and deasserts after edge TIMEOUT+1.

## Test plan
- Reset: hold rst_n=0 for 2 edges with arbitrary inputs -> wb_en=0, wb_addr=0, wb_data=0, mem_err=0, stall=0.
- Priority: in_valid=1, is_li=1, is_mem_access=1, is_move=1, immediate=8'h5A, dest_reg=3 -> next cycle wb_en=1, wb_addr=3, wb_data=8'h5A, stall never 1. Also is_move=1, reg_read_data=0, result=8'hFF -> wb_data=8'h00.
- Zero register: is_move=1, reg_read_data=8'h11, dest_reg=0 -> wb_en=0, wb_data=8'h11, wb_addr=0.
- Stalled load: is_mem_access=1, dest_reg=5, mem_ready=0 for 3 cycles, then mem_ready=1 with mem_data=8'hC3 -> stall=1 for 4 cycles, then wb_en=1, wb_addr=5, wb_data=8'hC3. During the wait, change dest_reg to 2 -> the write still goes to 5.
- Timeout with TIMEOUT=4: load issued, no ready -> mem_err pulses once after edge 4, wb_en stays 0, stall=0 afterwards. Repeat with mem_ready=1 on cycle 4 -> commit, no mem_err.
- Reset mid-wait: issue a load, drop rst_n for 1 edge in WAIT_MEM, then mem_ready=1 -> no wb_en, no mem_err, state is IDLE.
